// File: rtl/idli_sqi_mem_ctrl.sv
// rtl/idli_sqi_mem_ctrl.sv - SQI transaction engine: command, address, dummy and data nibble bursts
// Each nibble slot is an L cycle (sck=0) then an H cycle (sck=1); stalls stretch the H cycle.
module idli_sqi_mem_ctrl #(
  parameter int         ADDR_W    = 24,
  parameter int         NUM_CS    = 1,
  parameter int         LEN_W     = 8,
  parameter int         DUMMY_NIB = 2,
  parameter int         CS_IDLE   = 2,
  parameter logic [7:0] RD_CMD    = 8'h03,
  parameter logic [7:0] WR_CMD    = 8'h02
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_req_vld,
  output logic              o_sqi_req_acp,
  input  logic              i_sqi_req_wr,
  input  logic [ADDR_W-1:0] i_sqi_req_addr,
  input  logic [1:0]        i_sqi_req_cs,
  input  logic [LEN_W-1:0]  i_sqi_req_len,
  input  logic [3:0]        i_sqi_wdata,
  input  logic              i_sqi_wdata_vld,
  output logic              o_sqi_wdata_acp,
  output logic [3:0]        o_sqi_rdata,
  output logic              o_sqi_rdata_vld,
  input  logic              i_sqi_rdata_acp,
  output logic              o_sqi_sck,
  output logic [NUM_CS-1:0] o_sqi_cs,
  output logic              o_sqi_io_mode,
  output logic [3:0]        o_sqi_sio,
  input  logic [3:0]        i_sqi_sio
);

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIB - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cs_sel_q, cs_sel_d;
  logic [3:0]        sio_q, sio_d;
  logic [3:0]        rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic              wr_slot, rd_cap, active;

  // H cycle that precedes a write data slot; the next nibble is taken here
  assign wr_slot = phase_q & wr_q &
                   (((state_q == S_ADDR) & (cnt_q == ADDR_LAST)) |
                    ((state_q == S_DATA) & (len_q != '0)));
  assign rd_cap  = phase_q & ~wr_q & (state_q == S_DATA) & (~rvld_q | i_sqi_rdata_acp);
  assign active  = (state_q == S_CMD) | (state_q == S_ADDR) |
                   (state_q == S_DUMMY) | (state_q == S_DATA);

  always_ff @(posedge i_sqi_gck) begin
    if (!i_sqi_rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      cs_sel_q <= '0;
      sio_q    <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      cs_sel_q <= cs_sel_d;
      sio_q    <= sio_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    cs_sel_d = cs_sel_q;
    sio_d    = sio_q;
    rdata_d  = rdata_q;
    rvld_d   = rvld_q;
    if (i_sqi_rdata_acp) rvld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_sqi_req_vld) begin
          state_d  = S_CMD;
          phase_d  = 1'b0;
          cnt_d    = '0;
          wr_d     = i_sqi_req_wr;
          addr_d   = i_sqi_req_addr;
          cs_sel_d = i_sqi_req_cs;
          len_d    = i_sqi_req_len;
          sio_d    = i_sqi_req_wr ? WR_CMD[7:4] : RD_CMD[7:4];
        end
      end
      S_CMD: begin
        if (!phase_q) phase_d = 1'b1;
        else begin
          phase_d = 1'b0;
          if (cnt_q == '0) begin
            cnt_d = 8'd1;
            sio_d = wr_q ? WR_CMD[3:0] : RD_CMD[3:0];
          end else begin
            state_d = S_ADDR;
            cnt_d   = '0;
            sio_d   = addr_q[ADDR_W-1 -: 4];
            addr_d  = addr_q << 4;
          end
        end
      end
      S_ADDR: begin
        if (!phase_q) phase_d = 1'b1;
        else if (cnt_q != ADDR_LAST) begin
          phase_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          sio_d   = addr_q[ADDR_W-1 -: 4];
          addr_d  = addr_q << 4;
        end else if (!wr_q) begin
          phase_d = 1'b0;
          state_d = S_DUMMY;
          cnt_d   = '0;
        end else if (i_sqi_wdata_vld) begin
          phase_d = 1'b0;
          state_d = S_DATA;
          sio_d   = i_sqi_wdata;
        end
      end
      S_DUMMY: begin
        if (!phase_q) phase_d = 1'b1;
        else begin
          phase_d = 1'b0;
          if (cnt_q == DUMMY_LAST) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (!phase_q) phase_d = 1'b1;
        else if (wr_q) begin
          if (len_q == '0) begin
            state_d = S_END;
            phase_d = 1'b0;
            cnt_d   = '0;
            sio_d   = '0;
          end else if (i_sqi_wdata_vld) begin
            phase_d = 1'b0;
            sio_d   = i_sqi_wdata;
            len_d   = len_q - LEN_W'(1);
          end
        end else if (rd_cap) begin
          rdata_d = i_sqi_sio;
          rvld_d  = 1'b1;
          if (len_q == '0) begin
            state_d = S_END;
            phase_d = 1'b0;
            cnt_d   = '0;
            sio_d   = '0;
          end else begin
            phase_d = 1'b0;
            len_d   = len_q - LEN_W'(1);
          end
        end
      end
      S_END: begin
        if (cnt_q == IDLE_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_sqi_req_acp   = (state_q == S_IDLE);
    o_sqi_wdata_acp = wr_slot & i_sqi_wdata_vld;
    o_sqi_sck       = phase_q;
    o_sqi_sio       = sio_q;
    o_sqi_io_mode   = ~((state_q == S_DUMMY) | ((state_q == S_DATA) & ~wr_q));
    o_sqi_rdata     = rdata_q;
    o_sqi_rdata_vld = rvld_q;
    o_sqi_cs        = '1;
    // a device index beyond NUM_CS matches no bit, so no device is selected
    for (int i = 0; i < NUM_CS; i++) begin
      o_sqi_cs[i] = ~(active & (int'(cs_sel_q) == i));
    end
  end

endmodule

// File: tb/tb_idli_sqi_mem_ctrl.sv
// tb/tb_idli_sqi_mem_ctrl.sv - table-driven bench with sio/rdata scoreboards and a nibble memory model
module tb_idli_sqi_mem_ctrl;
  localparam int DUMMY_NIB = 2;
  localparam int CS_IDLE   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_wr = 1'b0;
  logic [23:0] req_addr = '0;
  logic [1:0]  req_cs = '0;
  logic [7:0]  req_len = '0;
  logic [3:0]  wdata = '0;
  logic        wdata_vld = 1'b0;
  logic        rdata_acp = 1'b1;
  logic [3:0]  sio_in = '0;

  logic        req_acp, wdata_acp, rdata_vld, sck, io_mode;
  logic [3:0]  rdata, sio_out;
  logic [3:0]  cs;
  logic        req_acp3, wdata_acp3, rdata_vld3, sck3, io_mode3;
  logic [3:0]  rdata3, sio_out3;
  logic [2:0]  cs3;

  always #5 clk = ~clk;

  idli_sqi_mem_ctrl #(.NUM_CS(4)) u_dut (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req_vld(req_vld), .o_sqi_req_acp(req_acp),
    .i_sqi_req_wr(req_wr), .i_sqi_req_addr(req_addr), .i_sqi_req_cs(req_cs), .i_sqi_req_len(req_len),
    .i_sqi_wdata(wdata), .i_sqi_wdata_vld(wdata_vld), .o_sqi_wdata_acp(wdata_acp),
    .o_sqi_rdata(rdata), .o_sqi_rdata_vld(rdata_vld), .i_sqi_rdata_acp(rdata_acp),
    .o_sqi_sck(sck), .o_sqi_cs(cs), .o_sqi_io_mode(io_mode), .o_sqi_sio(sio_out), .i_sqi_sio(sio_in)
  );

  idli_sqi_mem_ctrl #(.NUM_CS(3)) u_dut3 (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req_vld(req_vld), .o_sqi_req_acp(req_acp3),
    .i_sqi_req_wr(req_wr), .i_sqi_req_addr(req_addr), .i_sqi_req_cs(req_cs), .i_sqi_req_len(req_len),
    .i_sqi_wdata(wdata), .i_sqi_wdata_vld(wdata_vld), .o_sqi_wdata_acp(wdata_acp3),
    .o_sqi_rdata(rdata3), .o_sqi_rdata_vld(rdata_vld3), .i_sqi_rdata_acp(rdata_acp),
    .o_sqi_sck(sck3), .o_sqi_cs(cs3), .o_sqi_io_mode(io_mode3), .o_sqi_sio(sio_out3), .i_sqi_sio(sio_in)
  );

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [1:0]  cs;
    logic [7:0]  len;
    logic [15:0] d;
    int ws_s, ws_l, rs_s, rs_l, hs, hl;
    int exp_done, exp_cslow;
  } vec_t;

  vec_t tbl [8];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t0 = 0;
  int ws_s = 0, ws_l = 0, rs_s = 0, rs_l = 0;
  logic [3:0] sexp [$];
  logic [3:0] rexp [$];
  logic [3:0] wsrc [$];
  logic [3:0] rsrc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] d, input int i);
    logic [15:0] t;
    t = d << (4 * (i % 4));
    return t[15:12];
  endfunction

  function automatic logic [3:0] anib(input logic [23:0] a, input int j);
    logic [23:0] t;
    t = a << (4 * j);
    return t[23:20];
  endfunction

  // write-data source: nibbles offered from wsrc, withheld inside the stall window
  initial begin : wdrv
    int rel;
    forever begin
      @(negedge clk);
      #1;
      rel = cyc - t0;
      wdata_vld = (wsrc.size() > 0) && !(ws_l > 0 && rel >= ws_s && rel < ws_s + ws_l);
      wdata = (wsrc.size() > 0) ? wsrc[0] : 4'h0;
      #2;
      if (wdata_vld && wdata_acp) void'(wsrc.pop_front());
    end
  end

  // read side: memory model drives a nibble each data L cycle; consumer checks popped nibbles
  initial begin : rdrv
    int rel;
    int lcnt;
    lcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      rel = cyc - t0;
      rdata_acp = !(rs_l > 0 && rel >= rs_s && rel < rs_s + rs_l);
      if (io_mode) lcnt = 0;
      else if (!sck) begin
        if (lcnt >= DUMMY_NIB && rsrc.size() > 0) sio_in = rsrc.pop_front();
        lcnt++;
      end
      #2;
      if (rdata_vld && rdata_acp) begin
        if (rexp.size() == 0) chk("rdata_extra", 32'd1, 32'd0);
        else chk("rdata", {28'd0, rdata}, {28'd0, rexp.pop_front()});
      end
    end
  end

  // sio value seen by the memory at each SCK rise while the block drives the bus
  initial begin : smon
    logic prev_sck;
    prev_sck = 1'b0;
    forever begin
      @(negedge clk);
      if (sck && !prev_sck && io_mode) begin
        if (sexp.size() == 0) chk("sio_extra", 32'd1, 32'd0);
        else chk("sio", {28'd0, sio_out}, {28'd0, sexp.pop_front()});
      end
      prev_sck = sck;
    end
  end

  initial begin : gapmon
    int gap;
    bit seen_low;
    gap = 0;
    seen_low = 1'b0;
    forever begin
      @(negedge clk);
      if (cs != 4'hF) begin
        if (seen_low && gap > 0) chk("cs_gap", (gap >= CS_IDLE) ? 32'd1 : 32'd0, 32'd1);
        seen_low = 1'b1;
        gap = 0;
      end else gap++;
    end
  end

  task automatic issue(input vec_t v);
    logic [7:0] cmd;
    logic [3:0] n;
    t0 = cyc;
    ws_s = v.ws_s; ws_l = v.ws_l; rs_s = v.rs_s; rs_l = v.rs_l;
    req_vld = 1'b1; req_wr = v.wr; req_addr = v.addr; req_cs = v.cs; req_len = v.len;
    cmd = v.wr ? 8'h02 : 8'h03;
    sexp.push_back(cmd[7:4]);
    sexp.push_back(cmd[3:0]);
    for (int j = 0; j < 6; j++) sexp.push_back(anib(v.addr, j));
    for (int i = 0; i <= int'(v.len); i++) begin
      n = nib(v.d, i);
      if (v.wr) begin
        sexp.push_back(n);
        wsrc.push_back(n);
      end else begin
        rsrc.push_back(n);
        rexp.push_back(n);
      end
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge where req_acp is back
  task automatic run_vec(input int idx, input vec_t v);
    int cslow, done;
    bit oh_ok, hold_ok, c3_ok, busy3;
    logic [3:0] oh;
    cslow = 0; done = -1; oh_ok = 1; hold_ok = 1; c3_ok = 1; busy3 = 0;
    oh = ~(4'b0001 << v.cs);
    issue(v);
    for (int c = 1; c < 1000; c++) begin
      @(negedge clk);
      req_vld = 1'b0;
      if (cs != 4'hF) begin
        cslow++;
        if (cs != oh) oh_ok = 0;
      end
      if (cs3 != 3'b111) c3_ok = 0;
      if (!req_acp3) busy3 = 1;
      if (v.hl > 0 && c >= v.hs && c < v.hs + v.hl)
        if (!(sck && !cs[v.cs] && (!v.wr || sio_out == nib(v.d, 0)))) hold_ok = 0;
      if (req_acp) begin
        done = c;
        break;
      end
    end
    chk($sformatf("v%0d_done", idx), done, v.exp_done);
    chk($sformatf("v%0d_cslow", idx), cslow, v.exp_cslow);
    chk($sformatf("v%0d_cs_sel", idx), {31'd0, oh_ok}, 32'd1);
    if (v.hl > 0) chk($sformatf("v%0d_hold", idx), {31'd0, hold_ok}, 32'd1);
    if (v.cs == 2'd3) chk($sformatf("v%0d_dut3_nocs", idx), {30'd0, busy3, c3_ok}, 32'd3);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stuck at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin : main
    vec_t vr;
    tbl[0] = '{1'b1, 24'h123456, 2'd0, 8'd1,   16'hA500, 0,  0, 0,  0, 0,  0, 23,  20};
    tbl[1] = '{1'b0, 24'h000010, 2'd0, 8'd3,   16'hC39E, 0,  0, 0,  0, 0,  0, 31,  28};
    tbl[2] = '{1'b1, 24'hABCDEF, 2'd1, 8'd2,   16'h1230, 18, 5, 0,  0, 18, 5, 30,  27};
    tbl[3] = '{1'b0, 24'h0F0F0F, 2'd1, 8'd2,   16'h78F0, 0,  0, 23, 6, 24, 5, 34,  31};
    tbl[4] = '{1'b0, 24'h000004, 2'd2, 8'd0,   16'h6000, 0,  0, 0,  0, 0,  0, 25,  22};
    tbl[5] = '{1'b1, 24'h3A5C7E, 2'd3, 8'd0,   16'hB000, 0,  0, 0,  0, 0,  0, 21,  18};
    tbl[6] = '{1'b1, 24'hFFFFFF, 2'd2, 8'd3,   16'h0F0F, 0,  0, 0,  0, 0,  0, 27,  24};
    tbl[7] = '{1'b1, 24'h000000, 2'd0, 8'd255, 16'h1234, 0,  0, 0,  0, 0,  0, 531, 528};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {28'd0, cs}, 32'hF);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_io_mode", {31'd0, io_mode}, 32'd1);
    chk("rst_req_acp", {31'd0, req_acp}, 32'd1);
    chk("rst_sio", {28'd0, sio_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    vr = '{1'b0, 24'h000010, 2'd0, 8'd3, 16'hC39E, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(vr);
    repeat (24) begin
      @(negedge clk);
      req_vld = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cs", {28'd0, cs}, 32'hF);
    chk("abort_sck", {31'd0, sck}, 32'd0);
    chk("abort_io_mode", {31'd0, io_mode}, 32'd1);
    chk("abort_rdata_vld", {31'd0, rdata_vld}, 32'd0);
    chk("abort_req_acp", {31'd0, req_acp}, 32'd1);
    chk("abort_sio", {28'd0, sio_out}, 32'd0);
    chk("abort_wdata_acp", {31'd0, wdata_acp}, 32'd0);
    rexp.delete();
    rsrc.delete();
    sexp.delete();
    wsrc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cs", {28'd0, cs}, 32'hF);
    chk("rel_sck", {31'd0, sck}, 32'd0);
    chk("rel_io_mode", {31'd0, io_mode}, 32'd1);
    chk("rel_rdata_vld", {31'd0, rdata_vld}, 32'd0);
    chk("rel_req_acp", {31'd0, req_acp}, 32'd1);

    vr = '{1'b1, 24'h654321, 2'd1, 8'd0, 16'h9000, 0, 0, 0, 0, 0, 0, 21, 18};
    run_vec(8, vr);

    repeat (4) @(negedge clk);
    chk("sb_empty", rexp.size() + sexp.size() + wsrc.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
